// File: rtl/fft_spectrum_writer_if.sv
// Streaming FFT output bus plus display-RAM port A write signals.
// The FFT side drives dv/xk_*; the spectrum writer drives the RAM signals.
interface fft_spectrum_writer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic                     dv;
    logic [ADDR_W-1:0]        xk_index;
    logic signed [DATA_W-1:0] xk_re;
    logic signed [DATA_W-1:0] xk_im;
    logic                     wea;
    logic [ADDR_W:0]          addra;
    logic [7:0]               dina;

    modport master (
        output dv, xk_index, xk_re, xk_im,
        input  wea, addra, dina
    );

    modport slave (
        input  dv, xk_index, xk_re, xk_im,
        output wea, addra, dina
    );
endinterface

// File: rtl/fft_spectrum_writer.sv
// Writes scaled FFT bin magnitudes into the back bank of a double-buffered
// display RAM and swaps banks only after a complete, in-order frame.
module fft_spectrum_writer #(
    parameter int N_BINS  = 512,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int SHIFT   = 7,
    parameter int SKIP_DC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    fft_spectrum_writer_if.slave  fft_bus,
    output logic                  disp_bank,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [ADDR_W-1:0]     peak_index,
    output logic [7:0]            peak_mag
);

    localparam int PW = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        CAPTURE    = 2'd1,
        DRAIN      = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              w_accept;
    logic              w_seq_err;
    logic              w_swap;
    logic              w_pipe_empty;
    logic [ADDR_W-1:0] r_expected;

    // acceptance register
    logic                     r_acc_v;
    logic [ADDR_W-1:0]        r_acc_bin;
    logic                     r_acc_bank;
    logic signed [DATA_W-1:0] r_acc_re;
    logic signed [DATA_W-1:0] r_acc_im;

    // stage 1: squares
    logic signed [PW-1:0] w_re2;
    logic signed [PW-1:0] w_im2;
    logic                 r_s1_v;
    logic [ADDR_W-1:0]    r_s1_bin;
    logic                 r_s1_bank;
    logic [PW-1:0]        r_s1_re2;
    logic [PW-1:0]        r_s1_im2;

    // stage 2: sum, shift, saturate
    logic [PW-1:0]     w_sum;
    logic [PW-1:0]     w_scaled;
    logic [7:0]        w_sat;
    logic              r_s2_v;
    logic [ADDR_W-1:0] r_s2_bin;
    logic              r_s2_bank;
    logic [7:0]        r_s2_mag;

    // stage 3: RAM port registers
    logic              r_wea;
    logic [ADDR_W:0]   r_addra;
    logic [7:0]        r_dina;

    logic              r_disp_bank;
    logic              r_frame_done;
    logic              r_frame_err;
    logic [ADDR_W-1:0] r_trk_idx;
    logic [7:0]        r_trk_mag;
    logic [ADDR_W-1:0] r_peak_index;
    logic [7:0]        r_peak_mag;

    assign w_pipe_empty = !r_acc_v && !r_s1_v && !r_s2_v;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_seq_err    = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            WAIT_START: begin
                if (fft_bus.dv && enable && (fft_bus.xk_index == '0)) begin
                    w_accept     = 1'b1;
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (fft_bus.dv) begin
                    if (fft_bus.xk_index == r_expected) begin
                        w_accept = 1'b1;
                        if (fft_bus.xk_index == LAST_BIN) begin
                            w_state_next = DRAIN;
                        end
                    end else begin
                        w_seq_err    = 1'b1;
                        w_state_next = WAIT_START;
                    end
                end
            end
            DRAIN: begin
                if (w_pipe_empty) begin
                    w_swap       = 1'b1;
                    w_state_next = WAIT_START;
                end
            end
            default: w_state_next = WAIT_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_START;
            r_expected <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_expected <= fft_bus.xk_index + 1'b1;
            end
        end
    end

    assign w_re2    = r_acc_re * r_acc_re;
    assign w_im2    = r_acc_im * r_acc_im;
    assign w_sum    = r_s1_re2 + r_s1_im2;
    assign w_scaled = w_sum >> SHIFT;
    assign w_sat    = (|w_scaled[PW-1:8]) ? 8'hFF : w_scaled[7:0];

    // Valid bits and RAM outputs are reset so no in-flight write survives rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_v <= 1'b0;
            r_s1_v  <= 1'b0;
            r_s2_v  <= 1'b0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
        end else begin
            r_acc_v <= w_accept;
            r_s1_v  <= r_acc_v;
            r_s2_v  <= r_s1_v;
            r_wea   <= r_s2_v;
            if (r_s2_v) begin
                r_addra <= {r_s2_bank, r_s2_bin};
                r_dina  <= r_s2_mag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc_bin  <= fft_bus.xk_index;
            r_acc_bank <= ~r_disp_bank;
            r_acc_re   <= fft_bus.xk_re;
            r_acc_im   <= fft_bus.xk_im;
        end
        r_s1_bin  <= r_acc_bin;
        r_s1_bank <= r_acc_bank;
        r_s1_re2  <= $unsigned(w_re2);
        r_s1_im2  <= $unsigned(w_im2);
        r_s2_bin  <= r_s1_bin;
        r_s2_bank <= r_s1_bank;
        r_s2_mag  <= w_sat;
    end

    // Bin 0 reaching stage 2 marks a new frame; any leftovers of an aborted
    // frame are older, so restarting the tracker here discards them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trk_idx <= '0;
            r_trk_mag <= '0;
        end else if (r_s2_v) begin
            if (r_s2_bin == '0) begin
                r_trk_idx <= '0;
                r_trk_mag <= (SKIP_DC != 0) ? 8'd0 : r_s2_mag;
            end else if (r_s2_mag > r_trk_mag) begin
                r_trk_idx <= r_s2_bin;
                r_trk_mag <= r_s2_mag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_bank  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_peak_index <= '0;
            r_peak_mag   <= '0;
        end else begin
            r_frame_done <= w_swap;
            r_frame_err  <= w_seq_err;
            if (w_swap) begin
                r_disp_bank  <= ~r_disp_bank;
                r_peak_index <= r_trk_idx;
                r_peak_mag   <= r_trk_mag;
            end
        end
    end

    assign fft_bus.wea   = r_wea;
    assign fft_bus.addra = r_addra;
    assign fft_bus.dina  = r_dina;
    assign disp_bank     = r_disp_bank;
    assign frame_done    = r_frame_done;
    assign frame_err     = r_frame_err;
    assign peak_index    = r_peak_index;
    assign peak_mag      = r_peak_mag;

endmodule
